// File: rtl/udm_csr_resp.sv
// udm_csr_resp
//
// Bus responder for the board control/status register window
// 0x0000_0000 - 0x0000_000F, driven by the UART debug master (udm).
//
// Register map (word offsets, bits [3:2] of the byte address):
//   0x0 LED    RW, byte-enabled; led_o mirrors the low LED_WIDTH bits.
//   0x4 SW     RO, synchronized sw_i, zero-extended.
//   0x8 TIMER  RW countdown; a byte-enabled write loads over the live count.
//   0xC STATUS bit0 = done (sticky, write-1-to-clear), bit1 = running.
//
// Optional feature macro: UDM_CSR_TIMER_EN
//   defined   -> TIMER/STATUS registers and countdown logic are built.
//   undefined -> no timer logic; 0x8 and 0xC read 0, writes are ignored.
//
// Ports:
//   clk_i        system clock
//   rstn_i       asynchronous active-low reset
//   bus_req_i    request valid
//   bus_we_i     1 = write, 0 = read
//   bus_addr_i   byte address
//   bus_be_i     write byte enables
//   bus_wdata_i  write data
//   bus_ack_o    request accepted (combinational, equals bus_req_i)
//   bus_resp_o   read data valid, one-cycle pulse one cycle after accept
//   bus_rdata_o  registered read data, held until the next response
//   sw_i         asynchronous board switches
//   led_o        LED drive

module udm_csr_resp #(
    parameter int LED_WIDTH   = 16,
    parameter int SW_WIDTH    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 bus_req_i,
    input  logic                 bus_we_i,
    input  logic [31:0]          bus_addr_i,
    input  logic [3:0]           bus_be_i,
    input  logic [31:0]          bus_wdata_i,
    output logic                 bus_ack_o,
    output logic                 bus_resp_o,
    output logic [31:0]          bus_rdata_o,
    input  logic [SW_WIDTH-1:0]  sw_i,
    output logic [LED_WIDTH-1:0] led_o
);

    // A synchronizer shorter than two flops is not safe for metastability.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam logic [1:0] SEL_LED    = 2'd0;
    localparam logic [1:0] SEL_SW     = 2'd1;
    localparam logic [1:0] SEL_TIMER  = 2'd2;
    localparam logic [1:0] SEL_STATUS = 2'd3;

    logic                 mapped;
    logic [1:0]           reg_sel;
    logic                 wr_en;
    logic                 rd_en;
    logic [LED_WIDTH-1:0] led_q;
    logic [LED_WIDTH-1:0] led_next;
    logic [SW_WIDTH-1:0]  sw_sync_q [STAGES];
    logic [31:0]          timer_rdata;
    logic [31:0]          status_rdata;
    logic [31:0]          rdata_next;
    logic                 resp_q;
    logic [31:0]          rdata_q;
    logic                 unused_bits;

    assign mapped    = (bus_addr_i[31:4] == 28'd0);
    assign reg_sel   = bus_addr_i[3:2];
    // Unmapped writes are accepted but must not touch any register.
    assign wr_en     = bus_req_i & bus_we_i & mapped;
    // Unmapped reads still get a (zero) response.
    assign rd_en     = bus_req_i & ~bus_we_i;
    assign bus_ack_o = bus_req_i;

    // Byte-address low bits and write lanes beyond the implemented
    // registers carry no information for this block.
    assign unused_bits = ^{bus_addr_i[1:0], bus_wdata_i, bus_be_i};

    // LED register: merge the enabled byte lanes over the current value.
    always_comb begin
        led_next = led_q;
        for (int i = 0; i < LED_WIDTH; i++) begin
            if (bus_be_i[i >> 3]) begin
                led_next[i] = bus_wdata_i[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            led_q <= '0;
        end else if (wr_en && (reg_sel == SEL_LED)) begin
            led_q <= led_next;
        end
    end

    assign led_o = led_q;

    // Switch synchronizer chain; the last stage is what reads return.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int s = 0; s < STAGES; s++) begin
                sw_sync_q[s] <= '0;
            end
        end else begin
            sw_sync_q[0] <= sw_i;
            for (int s = 1; s < STAGES; s++) begin
                sw_sync_q[s] <= sw_sync_q[s-1];
            end
        end
    end

`ifdef UDM_CSR_TIMER_EN
    logic [31:0] count_q;
    logic [31:0] count_merged;
    logic        done_q;
    logic        running;
    logic        wr_timer;
    logic        wr_status;

    // The count only ever becomes non-zero through a load and stops at 0,
    // so "running" is exactly "count is non-zero".
    assign running   = (count_q != 32'd0);
    assign wr_timer  = wr_en && (reg_sel == SEL_TIMER);
    assign wr_status = wr_en && (reg_sel == SEL_STATUS);

    always_comb begin
        count_merged = count_q;
        for (int b = 0; b < 4; b++) begin
            if (bus_be_i[b]) begin
                count_merged[8*b +: 8] = bus_wdata_i[8*b +: 8];
            end
        end
    end

    // A load takes priority over the decrement, so loading in the 1->0
    // cycle suppresses done. The done set takes priority over W1C.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            count_q <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            if (wr_timer) begin
                count_q <= count_merged;
            end else if (running) begin
                count_q <= count_q - 32'd1;
            end

            if (!wr_timer && (count_q == 32'd1)) begin
                done_q <= 1'b1;
            end else if (wr_status && bus_be_i[0] && bus_wdata_i[0]) begin
                done_q <= 1'b0;
            end
        end
    end

    assign timer_rdata  = count_q;
    assign status_rdata = {30'd0, running, done_q};
`else
    assign timer_rdata  = 32'd0;
    assign status_rdata = 32'd0;
`endif

    always_comb begin
        rdata_next = 32'd0;
        if (mapped) begin
            case (reg_sel)
                SEL_LED:    rdata_next = 32'(led_q);
                SEL_SW:     rdata_next = 32'(sw_sync_q[STAGES-1]);
                SEL_TIMER:  rdata_next = timer_rdata;
                SEL_STATUS: rdata_next = status_rdata;
                default:    rdata_next = 32'd0;
            endcase
        end
    end

    // Read data is captured in the accept cycle and held until the next read.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            resp_q  <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            resp_q <= rd_en;
            if (rd_en) begin
                rdata_q <= rdata_next;
            end
        end
    end

    assign bus_resp_o  = resp_q;
    assign bus_rdata_o = rdata_q;

endmodule

// File: tb/tb_udm_csr_resp.sv
// tb_udm_csr_resp
//
// Directed bench for udm_csr_resp. Reads push their expected data into a
// scoreboard queue; an independent monitor pops and compares whenever the
// DUT pulses bus_resp_o, and also checks that every resp pulse comes exactly
// one cycle after a read accept. Timer expectations follow the
// UDM_CSR_TIMER_EN macro (zero when the timer is not built).

module tb_udm_csr_resp;

`ifdef UDM_CSR_TIMER_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif

    logic        clk_i;
    logic        rstn_i;
    logic        bus_req_i;
    logic        bus_we_i;
    logic [31:0] bus_addr_i;
    logic [3:0]  bus_be_i;
    logic [31:0] bus_wdata_i;
    logic        bus_ack_o;
    logic        bus_resp_o;
    logic [31:0] bus_rdata_o;
    logic [15:0] sw_i;
    logic [15:0] led_o;

    int          checks;
    int          errors;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic        rd_last;

    udm_csr_resp #(
        .LED_WIDTH  (16),
        .SW_WIDTH   (16),
        .SYNC_STAGES(2)
    ) dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .bus_req_i  (bus_req_i),
        .bus_we_i   (bus_we_i),
        .bus_addr_i (bus_addr_i),
        .bus_be_i   (bus_be_i),
        .bus_wdata_i(bus_wdata_i),
        .bus_ack_o  (bus_ack_o),
        .bus_resp_o (bus_resp_o),
        .bus_rdata_o(bus_rdata_o),
        .sw_i       (sw_i),
        .led_o      (led_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Remembers whether a read was accepted on the most recent edge.
    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) rd_last <= 1'b0;
        else         rd_last <= bus_req_i && !bus_we_i;
    end

    // Monitor: response timing and scoreboard data.
    always @(negedge clk_i) begin
        if (rstn_i) begin
            if (bus_resp_o || rd_last) begin
                checks++;
                if (bus_resp_o !== rd_last) begin
                    errors++;
                    $display("[TB] FAIL resp_timing: got resp=%0b expected resp=%0b", bus_resp_o, rd_last);
                end
            end
            if (bus_resp_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_resp: got rdata=%08h expected no response", bus_rdata_o);
                end else begin
                    logic [31:0] e;
                    string t;
                    e = exp_q.pop_front();
                    t = tag_q.pop_front();
                    if (bus_rdata_o !== e) begin
                        errors++;
                        $display("[TB] FAIL %s: got %08h expected %08h", t, bus_rdata_o, e);
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    // Drives one bus cycle; called just after a rising edge, returns just
    // after the edge on which the request was accepted.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                                 input logic [31:0] wdata, input logic [31:0] exp, input string tag);
        bus_req_i   = 1'b1;
        bus_we_i    = we;
        bus_addr_i  = addr;
        bus_be_i    = be;
        bus_wdata_i = wdata;
        if (!we) begin
            exp_q.push_back(exp);
            tag_q.push_back(tag);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
        applyStimulus(1'b1, addr, be, data, 32'd0, "");
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        applyStimulus(1'b0, addr, 4'h0, 32'd0, exp, tag);
    endtask

    task automatic idle(input int n);
        bus_req_i = 1'b0;
        bus_we_i  = 1'b0;
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rstn_i      = 1'b0;
        bus_req_i   = 1'b0;
        bus_we_i    = 1'b0;
        bus_addr_i  = 32'd0;
        bus_be_i    = 4'h0;
        bus_wdata_i = 32'd0;
        sw_i        = 16'h0000;

        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("reset_resp",  {31'd0, bus_resp_o}, 32'd0);
        checkOutput("reset_rdata", bus_rdata_o, 32'd0);
        checkOutput("reset_led",   {16'd0, led_o}, 32'd0);
        rstn_i = 1'b1;
        idle(1);

        // LED full write, then read back
        wr(32'h0, 4'hF, 32'h5a5a5a5a);
        checkOutput("led_full_write", {16'd0, led_o}, 32'h00005a5a);
        rd(32'h0, 32'h00005a5a, "rd_led_full");
        checkOutput("ack_follows_req", {31'd0, bus_ack_o}, 32'd1);
        idle(1);
        checkOutput("ack_idle", {31'd0, bus_ack_o}, 32'd0);

        // Read-after-write in consecutive cycles
        wr(32'h0, 4'hF, 32'h00001234);
        rd(32'h0, 32'h00001234, "rd_after_wr");

        // Byte-enabled LED write: only byte1 updated (with 0x00)
        wr(32'h0, 4'hF, 32'h0000FFFF);
        wr(32'h0, 4'b0010, 32'h12000000);
        checkOutput("led_byte_en", {16'd0, led_o}, 32'h000000FF);
        rd(32'h0, 32'h000000FF, "rd_led_byte_en");
        idle(3);
        checkOutput("rdata_held", bus_rdata_o, 32'h000000FF);

        // Switch input, read-only, synchronizer latency
        sw_i = 16'h0030;
        idle(3);
        rd(32'h4, 32'h00000030, "rd_sw");
        wr(32'h4, 4'hF, 32'hFFFFFFFF);
        rd(32'h4, 32'h00000030, "rd_sw_after_wr");
        idle(1);
        sw_i = 16'h00A5;
        idle(1);
        rd(32'h4, 32'h00000030, "rd_sw_before_sync");
        rd(32'h4, 32'h000000A5, "rd_sw_after_sync");

        // Countdown of 5: running for 5 cycles, done in the 6th
        wr(32'h8, 4'hF, 32'd5);
        for (int j = 1; j <= 7; j++) begin
            rd(32'hC, TIMER_EN ? ((j <= 5) ? 32'h2 : 32'h1) : 32'h0, $sformatf("rd_status_t%0d", j));
        end
        wr(32'hC, 4'hF, 32'h1);
        rd(32'hC, 32'h0, "rd_status_cleared");
        rd(32'h8, 32'h0, "rd_timer_expired");

        // Byte-enabled load over the live count
        wr(32'h8, 4'hF, 32'h00000100);
        wr(32'h8, 4'b0001, 32'h00000050);
        rd(32'h8, TIMER_EN ? 32'h00000150 : 32'h0, "rd_timer_byte_en");
        wr(32'h8, 4'hF, 32'h0);
        rd(32'hC, 32'h0, "rd_status_load_zero");

        // Load in the 1->0 cycle wins; done stays clear
        wr(32'h8, 4'hF, 32'd2);
        idle(1);
        wr(32'h8, 4'hF, 32'd7);
        rd(32'hC, TIMER_EN ? 32'h2 : 32'h0, "rd_status_load_wins");
        rd(32'h8, TIMER_EN ? 32'd6 : 32'h0, "rd_timer_reloaded");
        wr(32'h8, 4'hF, 32'h0);
        rd(32'hC, 32'h0, "rd_status_stopped");

        // W1C in the cycle done is set: set wins
        wr(32'h8, 4'hF, 32'd3);
        idle(2);
        wr(32'hC, 4'hF, 32'h1);
        rd(32'hC, TIMER_EN ? 32'h1 : 32'h0, "rd_status_set_wins");
        wr(32'hC, 4'hF, 32'h1);
        rd(32'hC, 32'h0, "rd_status_w1c");

        // Unmapped accesses, then back-to-back reads
        rd(32'h20, 32'h0, "rd_unmapped");
        wr(32'h20, 4'hF, 32'hDEADBEEF);
        checkOutput("led_unmapped_wr", {16'd0, led_o}, 32'h000000FF);
        rd(32'h0, 32'h000000FF, "b2b_led");
        rd(32'h4, 32'h000000A5, "b2b_sw");
        rd(32'hC, 32'h0, "b2b_status");
        idle(2);

        // Long count, then reset mid-count
        wr(32'h8, 4'hF, 32'h00017ED0);
        idle(99);
        rd(32'h8, TIMER_EN ? (32'h00017ED0 - 32'd99) : 32'h0, "rd_timer_long");
        idle(2);
        rstn_i = 1'b0;
        #1;
        checkOutput("midreset_resp",  {31'd0, bus_resp_o}, 32'd0);
        checkOutput("midreset_rdata", bus_rdata_o, 32'd0);
        checkOutput("midreset_led",   {16'd0, led_o}, 32'd0);
        exp_q.delete();
        tag_q.delete();
        idle(2);
        rstn_i = 1'b1;
        idle(2);
        rd(32'h8, 32'h0, "rd_timer_after_reset");
        rd(32'hC, 32'h0, "rd_status_after_reset");
        rd(32'h0, 32'h0, "rd_led_after_reset");
        idle(1);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            idle(1);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending responses expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
